// File: rtl/i2c_target.sv
// i2c_target: I2C target endpoint with a DEPTH x 8 register file,
// auto-incrementing pointer, local read port and write strobe.
// Ports: clk; rst (async, active-low); scl_in/sda_in (raw pads);
// sda_oe (1 = pull SDA low); host_addr/host_data (local read);
// wr_stb/wr_idx (bus-write notify); busy (addressed transfer).
module i2c_target #(
  parameter logic [6:0] SLV_ADDR   = 7'd10,
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH      = 16,
  localparam int         IW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [IW-1:0]         host_addr,
  output logic [DATA_WIDTH-1:0] host_data,
  output logic                  wr_stb,
  output logic [IW-1:0]         wr_idx,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  localparam logic [3:0] NB   = 4'(DATA_WIDTH);
  localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [2:0]            scl_q, sda_q;
  logic                  scl_rise, scl_fall;
  logic                  start, stop, sda;
  logic                  byte_end, ack_end;
  logic                  addr_match, oe_d;
  logic                  rw, nack;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] sh, sh_in;
  logic [IW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // [0],[1] synchronize; [2] is the previous value for edges.
  // Reset to 1 so an idle bus produces no edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];

  // cnt counts SCL rises; a byte closes on the fall after
  // its 8th rise, an ACK slot on the fall after one rise.
  assign byte_end   = scl_fall & (cnt == NB);
  assign ack_end    = scl_fall & (cnt == 4'd1);
  assign sh_in      = {sh[DATA_WIDTH-2:0], sda};
  assign addr_match = sh[DATA_WIDTH-1:1] == SLV_ADDR;
  assign host_data  = regs[host_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ADDR;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ADDR:
          if (byte_end)
            state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:
          if (ack_end) state_d = rw ? RDATA : REG;
        REG:
          if (byte_end) state_d = REG_ACK;
        REG_ACK:
          if (ack_end) state_d = WDATA;
        WDATA:
          if (byte_end) state_d = WDATA_ACK;
        WDATA_ACK:
          if (ack_end) state_d = WDATA;
        RDATA:
          if (byte_end) state_d = RACK;
        RACK:
          if (ack_end) state_d = nack ? IGNORE : RDATA;
        default: ;
      endcase
    end
  end

  // oe_d: SDA drive for the next clk. It only moves on an
  // SCL fall, except START/STOP which release at once.
  always_comb begin
    busy = 1'b1;
    oe_d = sda_oe;
    unique case (state_q)
      IDLE, ADDR, IGNORE: busy = 1'b0;
      default:            busy = 1'b1;
    endcase
    if (start || stop) begin
      oe_d = 1'b0;
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR:
          if (byte_end) oe_d = addr_match;
        REG, WDATA:
          if (byte_end) oe_d = 1'b1;
        ADDR_ACK:
          if (ack_end)
            oe_d = rw & ~regs[ptr][DATA_WIDTH-1];
        REG_ACK, WDATA_ACK:
          if (ack_end) oe_d = 1'b0;
        RDATA:
          oe_d = byte_end ? 1'b0 : ~sh[DATA_WIDTH-2];
        RACK:
          if (ack_end)
            oe_d = ~nack & ~regs[ptr][DATA_WIDTH-1];
        default: oe_d = 1'b0;
      endcase
    end
  end

  // Register writes and pointer moves happen only on the 8th
  // rise, so a START/STOP inside a byte leaves both alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_oe <= 1'b0;
      wr_stb <= 1'b0;
      wr_idx <= '0;
      ptr    <= '0;
      cnt    <= '0;
      sh     <= '0;
      rw     <= 1'b0;
      nack   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      sda_oe <= oe_d;
      wr_stb <= 1'b0;
      if (start || stop) begin
        cnt <= '0;
      end else if (scl_rise) begin
        cnt <= cnt + 4'd1;
        unique case (state_q)
          ADDR: sh <= sh_in;
          REG: begin
            sh <= sh_in;
            if (cnt == LAST) ptr <= sh_in[IW-1:0];
          end
          WDATA: begin
            sh <= sh_in;
            if (cnt == LAST) begin
              regs[ptr] <= sh_in;
              wr_stb    <= 1'b1;
              wr_idx    <= ptr;
              ptr       <= ptr + IW'(1);
            end
          end
          RDATA:
            if (cnt == LAST) ptr <= ptr + IW'(1);
          RACK: nack <= sda;
          default: ;
        endcase
      end else if (scl_fall) begin
        if (state_d != state_q) cnt <= '0;
        if (state_q == ADDR) rw <= sh[0];
        if (state_q == RDATA) sh <= sh << 1;
        else if (state_d == RDATA) sh <= regs[ptr];
      end
    end
  end

endmodule
